gc_gibbs_sweep_ctrl: RTL and testbench

//  Sequential update controller for the graph-colouring vector-multiply stage (vecmul_gc).
//  - Walks every node and every colour bit of that node.
//  - Drives node_count/color_bit_count into vecmul_gc and samples its combinational product.
//  - Decides the new bit value and writes it back into the node-state register that feeds vecmul_gc.nodes.
//  - Repeats for a programmable number of full sweeps, then signals done.

---
 rtl/gc_gibbs_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_gc_gibbs_sweep_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gc_gibbs_sweep_ctrl.sv
// Sequential (Gibbs) sweep controller for the graph-colouring vecmul stage.
// Optional GC_NOISE_EN adds a 16-bit LFSR threshold for stochastic bit decisions.
module gc_gibbs_sweep_ctrl #(
    parameter int          PRECISION_BITS  = 4,
    parameter int          OVERFLOW_BITS   = 4,
    parameter int          NUM_NODES       = 4,
    parameter int          NUM_NODES_BIT   = 2,
    parameter int          NUM_COLORS      = 4,
    parameter int          NUM_COLORS_BITS = 2,
    parameter int          SWEEP_BITS      = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int         PAD_BITS        = PRECISION_BITS + OVERFLOW_BITS,
    localparam int         CBC_W           = (NUM_COLORS_BITS > 1) ? $clog2(NUM_COLORS_BITS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [NUM_NODES*NUM_COLORS_BITS-1:0] nodes_init,
    input  logic                                 start,
    input  logic [SWEEP_BITS-1:0]                num_sweeps,
    input  logic [PAD_BITS-1:0]                  product,
    output logic [NUM_NODES*NUM_COLORS_BITS-1:0] nodes,
    output logic [NUM_NODES_BIT-1:0]             node_count,
    output logic [CBC_W-1:0]                     color_bit_count,
    output logic                                 busy,
    output logic                                 done
);
    localparam logic [NUM_COLORS_BITS:0] NC = NUM_COLORS[NUM_COLORS_BITS:0];

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;
    state_t state, state_nxt;

    logic [SWEEP_BITS-1:0]      sweep_cnt, sweeps_q;
    logic signed [PAD_BITS-1:0] thr;
    logic [NUM_COLORS_BITS-1:0] cur_color, cand;
    logic                       newbit, accept, last_bit, last_node, last_sweep;

`ifdef GC_NOISE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 lfsr <= LFSR_SEED;
        else if (state == UPDATE) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign thr = $signed(lfsr[PAD_BITS-1:0]);
`else
    assign thr = '0;
`endif

    always_comb begin
        cur_color  = nodes[int'(node_count)*NUM_COLORS_BITS +: NUM_COLORS_BITS];
        newbit     = ($signed(product) > thr);
        cand       = cur_color;
        cand[color_bit_count] = newbit;
        // Colour codes at or above NUM_COLORS are illegal; such a flip is dropped.
        accept     = ({1'b0, cand} < NC);
        last_bit   = (color_bit_count == CBC_W'(NUM_COLORS_BITS - 1));
        last_node  = (node_count == NUM_NODES_BIT'(NUM_NODES - 1));
        last_sweep = ((sweep_cnt + SWEEP_BITS'(1)) == sweeps_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!load && start) state_nxt = (num_sweeps == '0) ? DONE : EVAL;
            EVAL:    state_nxt = UPDATE;
            UPDATE:  if (last_bit && last_node && last_sweep) state_nxt = DONE;
                     else                                     state_nxt = EVAL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EVAL) || (state == UPDATE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nodes           <= '0;
            node_count      <= '0;
            color_bit_count <= '0;
            sweep_cnt       <= '0;
            sweeps_q        <= '0;
            done            <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (load) begin
                        nodes <= nodes_init;
                    end else if (start) begin
                        sweeps_q        <= num_sweeps;
                        sweep_cnt       <= '0;
                        node_count      <= '0;
                        color_bit_count <= '0;
                    end
                end
                UPDATE: begin
                    if (accept) nodes[int'(node_count)*NUM_COLORS_BITS +: NUM_COLORS_BITS] <= cand;
                    if (last_bit) begin
                        color_bit_count <= '0;
                        if (last_node) begin
                            node_count <= '0;
                            sweep_cnt  <= sweep_cnt + SWEEP_BITS'(1);
                        end else begin
                            node_count <= node_count + NUM_NODES_BIT'(1);
                        end
                    end else begin
                        color_bit_count <= color_bit_count + CBC_W'(1);
                    end
                end
                DONE: begin
                    node_count      <= '0;
                    color_bit_count <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gc_gibbs_sweep_ctrl.sv
// Scoreboard bench for gc_gibbs_sweep_ctrl: a 4-colour and a 3-colour instance run in lockstep.
module tb_gc_gibbs_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst, load, start;
    logic [7:0] nodes_init, num_sweeps, product;
    logic [7:0] nodes, nodes3;
    logic [1:0] node_count, node_count3;
    logic [0:0] cbc, cbc3;
    logic       busy, busy3, done, done3;

    always #5 clk = ~clk;

    gc_gibbs_sweep_ctrl dut (
        .clk(clk), .rst(rst), .load(load), .nodes_init(nodes_init), .start(start),
        .num_sweeps(num_sweeps), .product(product), .nodes(nodes), .node_count(node_count),
        .color_bit_count(cbc), .busy(busy), .done(done));

    gc_gibbs_sweep_ctrl #(.NUM_COLORS(3)) dut3 (
        .clk(clk), .rst(rst), .load(load), .nodes_init(nodes_init), .start(start),
        .num_sweeps(num_sweeps), .product(product), .nodes(nodes3), .node_count(node_count3),
        .color_bit_count(cbc3), .busy(busy3), .done(done3));

    typedef struct {
        logic [7:0] n;
        logic [7:0] n3;
        int         cyc;
    } done_t;

    done_t      done_q[$];
    logic [2:0] idx_q[$];
    int         tests = 0, fails = 0, cyc = 0;
    logic [2:0] e;
    done_t      d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every busy cycle consumes one expected index, every done pulse one result.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (idx_q.size() == 0) chk("busy_unexpected", 32'(busy), 32'd0);
                else begin
                    e = idx_q.pop_front();
                    chk("index", 32'({node_count, cbc}), 32'(e));
                end
            end
            if (done || done3) chk("done_nc3_align", 32'(done3), 32'(done));
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("nodes", 32'(nodes), 32'(d.n));
                    chk("nodes_nc3", 32'(nodes3), 32'(d.n3));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        nodes_init = v; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    // Called 1 time unit after an edge; start is sampled at the next edge (cyc+1).
    task automatic run_start(input int n, input logic [7:0] exp_n, input logic [7:0] exp_n3);
        done_t r;
        for (int s = 0; s < n; s++)
            for (int nd = 0; nd < 4; nd++)
                for (int b = 0; b < 2; b++) begin
                    idx_q.push_back({2'(nd), 1'(b)});
                    idx_q.push_back({2'(nd), 1'(b)});
                end
        r.n = exp_n; r.n3 = exp_n3; r.cyc = cyc + 2 + 16 * n;
        done_q.push_back(r);
        num_sweeps = 8'(n); start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_q.size() != 0 && k < 2000) begin tick(1); k++; end
        chk("run_complete", 32'(done_q.size()), 32'd0);
        chk("idx_drained", 32'(idx_q.size()), 32'd0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0;
        nodes_init = '0; num_sweeps = '0; product = '0;
        tick(2);
        chk("rst_nodes", 32'(nodes), 32'd0);
        chk("rst_node_count", 32'(node_count), 32'd0);
        chk("rst_cbc", 32'(cbc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick(1);

        // Reset mid-run: outputs return to reset values without waiting for an edge.
        do_load(8'hE4);
        product = 8'd5;
        run_start(1, 8'hFF, 8'hE5);
        tick(5);
        chk("mid_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_nodes", 32'(nodes), 32'd0);
        chk("async_rst_node_count", 32'(node_count), 32'd0);
        chk("async_rst_cbc", 32'(cbc), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        idx_q.delete();
        done_q.delete();
        tick(1);
        rst = 1'b0;
        tick(3);

        // load beats start in the same cycle: no run may begin.
        nodes_init = 8'hE4; load = 1'b1; start = 1'b1; num_sweeps = 8'd1;
        tick(1);
        load = 1'b0; start = 1'b0;
        tick(3);
        chk("load_wins", 32'(nodes), 32'hE4);

        // Zero sweeps: straight to DONE, nodes untouched.
        run_start(0, 8'hE4, 8'hE4);
        wait_done();

        // Positive product, one sweep: all bits set; 3-colour instance rejects colour 3.
        do_load(8'h00);
        product = 8'd5;
        run_start(1, 8'hFF, 8'h55);
        wait_done();

        // Zero product is not > 0 (strict), then a negative product: all bits cleared.
        do_load(8'hFF);
        product = 8'd0;
        run_start(2, 8'h00, 8'h00);
        wait_done();
        do_load(8'hFF);
        product = 8'hFD;
        run_start(2, 8'h00, 8'h00);
        wait_done();

        // start while busy and load during EVAL are both ignored.
        do_load(8'hE4);
        product = 8'd5;
        run_start(1, 8'hFF, 8'hE5);
        tick(2);
        nodes_init = 8'h00; load = 1'b1;
        tick(1);
        load = 1'b0;
        num_sweeps = 8'd5; start = 1'b1;
        tick(2);
        start = 1'b0;
        wait_done();
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
